// File: rtl/cp0_exception_ctrl.sv
// CP0 Status/Cause/EPC registers with a three-state exception entry sequencer.
// Entry at edge N gives flush at N+1 and a redirect to EXC_VECTOR at N+2; there is no backpressure.
module cp0_exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pendingexception,
  input  logic [4:0]  exccode,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [5:0]  interrupts_in,
  input  logic        rfe,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  output logic        iec,
  output logic [7:0]  ip_masked,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        exc_busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  status_im;
  logic [5:0]  status_ku;
  logic        cause_bd;
  logic [5:0]  cause_iphw;
  logic [1:0]  cause_ipsw;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic take_exc, take_rfe, wr_status, wr_cause, wr_epc;

  assign take_exc  = (state == IDLE) && pendingexception;
  assign take_rfe  = (state == IDLE) && rfe && !pendingexception;
  assign wr_status = mtc0_we && (mtc0_addr == 5'd12);
  assign wr_cause  = mtc0_we && (mtc0_addr == 5'd13);
  assign wr_epc    = mtc0_we && (mtc0_addr == 5'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pendingexception) state_nxt = FLUSH;
      FLUSH:    state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_im  <= '0;
      status_ku  <= '0;
      cause_bd   <= 1'b0;
      cause_iphw <= '0;
      cause_ipsw <= '0;
      cause_exc  <= '0;
      epc        <= '0;
    end else begin
      cause_iphw <= interrupts_in;
      if (wr_status) status_im <= mtc0_wdata[15:8];
      if (wr_cause)  cause_ipsw <= mtc0_wdata[9:8];
      // Entry and rfe both own the KU/IE stack, so they win over a software write.
      if (take_exc)       status_ku <= {status_ku[3:0], 2'b00};
      else if (take_rfe)  status_ku <= {status_ku[5:4], status_ku[5:2]};
      else if (wr_status) status_ku <= mtc0_wdata[5:0];
      if (take_exc) begin
        cause_exc <= exccode;
        cause_bd  <= exc_bd;
        epc       <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
      end else if (wr_epc) begin
        epc <= mtc0_wdata;
      end
    end
  end

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      5'd12:   mfc0_rdata = {16'b0, status_im, 2'b00, status_ku};
      5'd13:   mfc0_rdata = {cause_bd, 15'b0, cause_iphw, cause_ipsw, 1'b0, cause_exc, 2'b00};
      5'd14:   mfc0_rdata = epc;
      default: mfc0_rdata = '0;
    endcase
  end

  assign iec         = status_ku[0];
  assign ip_masked   = {cause_iphw, cause_ipsw} & status_im;
  assign flush       = (state == FLUSH);
  assign pc_redirect = (state == REDIRECT);
  assign exc_busy    = (state != IDLE);
  assign redirect_pc = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed table of post-edge expectations for cp0_exception_ctrl, plus reset corner sequences.
module tb_cp0_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pendingexception;
  logic [4:0]  exccode;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [5:0]  interrupts_in;
  logic        rfe;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic        iec;
  logic [7:0]  ip_masked;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        exc_busy;

  cp0_exception_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pendingexception(pendingexception), .exccode(exccode),
    .exc_pc(exc_pc), .exc_bd(exc_bd), .interrupts_in(interrupts_in), .rfe(rfe),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata), .iec(iec), .ip_masked(ip_masked),
    .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .exc_busy(exc_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pe;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [5:0]  intr;
    logic        rfe;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        fl;
    logic        rx;
    logic        busy;
    logic        ie;
    logic [7:0]  ipm;
  } vec_t;

  vec_t vq[$];
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else npass++;
  endtask

  task automatic idle_inputs();
    pendingexception = 0; exccode = 0; exc_pc = 0; exc_bd = 0; interrupts_in = 0;
    rfe = 0; mtc0_we = 0; mtc0_addr = 0; mtc0_wdata = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    mfc0_addr = 5'd0;
    idle_inputs();

    //             pe code  pc            bd intr   rfe we wa     wd             ra     rd             fl rx bsy ie ipm
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd12, 32'h1,         5'd12, 32'h1,         0, 0, 0, 1, 8'h00});
    vq.push_back(vec_t'{1, 5'd8,  32'h0040_0010,0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd14, 32'h0040_0010, 1, 0, 1, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd13, 32'h20,        0, 1, 1, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd12, 32'h04,        0, 0, 0, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 1, 0, 5'd0,  32'h0,         5'd12, 32'h01,        0, 0, 0, 1, 8'h00});
    vq.push_back(vec_t'{1, 5'd4,  32'h0040_0024,1, 6'h00, 0, 0, 5'd0,  32'h0,         5'd14, 32'h0040_0020, 1, 0, 1, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd13, 32'h8000_0010, 0, 1, 1, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd12, 32'h04,        0, 0, 0, 0, 8'h00});
    vq.push_back(vec_t'{1, 5'd0,  32'h0,        1, 6'h00, 0, 0, 5'd0,  32'h0,         5'd14, 32'hFFFF_FFFC, 1, 0, 1, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd14, 32'hFFFF_FFFC, 0, 1, 1, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd12, 32'h10,        0, 0, 0, 0, 8'h00});
    // interrupt loop
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd12, 32'h8001,      5'd12, 32'h8001,      0, 0, 0, 1, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h20, 0, 0, 5'd0,  32'h0,         5'd13, 32'h8000_8000, 0, 0, 0, 1, 8'h80});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h20, 0, 1, 5'd12, 32'h0001,      5'd12, 32'h1,         0, 0, 0, 1, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h8000_0300, 0, 0, 0, 1, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd12, 32'h0301,      5'd12, 32'h0301,      0, 0, 0, 1, 8'h03});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd13, 32'h0,         5'd13, 32'h8000_0000, 0, 0, 0, 1, 8'h00});
    // held exception, EPC write loses to entry, rfe ignored while busy
    vq.push_back(vec_t'{1, 5'd12, 32'h100,      0, 6'h00, 0, 1, 5'd14, 32'h1234,      5'd14, 32'h100,       1, 0, 1, 0, 8'h00});
    vq.push_back(vec_t'{1, 5'd5,  32'h200,      0, 6'h00, 1, 0, 5'd0,  32'h0,         5'd12, 32'h0304,      0, 1, 1, 0, 8'h00});
    vq.push_back(vec_t'{1, 5'd5,  32'h200,      0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd14, 32'h100,       0, 0, 0, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 1, 0, 5'd0,  32'h0,         5'd12, 32'h0301,      0, 0, 0, 1, 8'h00});
    vq.push_back(vec_t'{1, 5'd9,  32'h300,      0, 6'h00, 1, 0, 5'd0,  32'h0,         5'd12, 32'h0304,      1, 0, 1, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd13, 32'h24,        0, 1, 1, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 0, 5'd0,  32'h0,         5'd12, 32'h0304,      0, 0, 0, 0, 8'h00});
    // unimplemented register, EPC write, Status masking, rfe over MTC0
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd5,  32'hFFFF_FFFF, 5'd5,  32'h0,         0, 0, 0, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF, 0, 0, 0, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0000_FF3F, 0, 0, 0, 1, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 0, 1, 5'd12, 32'h24,        5'd12, 32'h24,        0, 0, 0, 0, 8'h00});
    vq.push_back(vec_t'{0, 5'd0,  32'h0,        0, 6'h00, 1, 1, 5'd12, 32'h0,         5'd12, 32'h29,        0, 0, 0, 1, 8'h00});

    // reset state
    #12;
    chk("rst flush", {31'b0, flush}, 32'h0);
    chk("rst pc_redirect", {31'b0, pc_redirect}, 32'h0);
    chk("rst exc_busy", {31'b0, exc_busy}, 32'h0);
    chk("rst iec", {31'b0, iec}, 32'h0);
    chk("rst ip_masked", {24'b0, ip_masked}, 32'h0);
    for (int a = 12; a <= 14; a++) begin
      mfc0_addr = 5'(a);
      #1 chk($sformatf("rst rdata r%0d", a), mfc0_rdata, 32'h0);
    end

    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      pendingexception = vq[i].pe;  exccode = vq[i].code; exc_pc = vq[i].pc; exc_bd = vq[i].bd;
      interrupts_in = vq[i].intr;   rfe = vq[i].rfe;      mtc0_we = vq[i].we;
      mtc0_addr = vq[i].wa;         mtc0_wdata = vq[i].wd; mfc0_addr = vq[i].ra;
      @(posedge clk); #1;
      chk($sformatf("v%0d rdata", i), mfc0_rdata, vq[i].rd);
      chk($sformatf("v%0d flush", i), {31'b0, flush}, {31'b0, vq[i].fl});
      chk($sformatf("v%0d pc_redirect", i), {31'b0, pc_redirect}, {31'b0, vq[i].rx});
      chk($sformatf("v%0d exc_busy", i), {31'b0, exc_busy}, {31'b0, vq[i].busy});
      chk($sformatf("v%0d iec", i), {31'b0, iec}, {31'b0, vq[i].ie});
      chk($sformatf("v%0d ip_masked", i), {24'b0, ip_masked}, {24'b0, vq[i].ipm});
      if (vq[i].rx) chk($sformatf("v%0d redirect_pc", i), redirect_pc, 32'h8000_0080);
      @(negedge clk);
    end

    // reset in FLUSH aborts the sequence
    idle_inputs();
    pendingexception = 1; exccode = 5'd3; exc_pc = 32'h40;
    @(posedge clk); #1;
    chk("mid flush before reset", {31'b0, flush}, 32'h1);
    #2 rst_n = 1'b0; pendingexception = 0;
    #1;
    chk("mid flush in reset", {31'b0, flush}, 32'h0);
    chk("mid busy in reset", {31'b0, exc_busy}, 32'h0);
    chk("mid redirect in reset", {31'b0, pc_redirect}, 32'h0);
    for (int a = 12; a <= 14; a++) begin
      mfc0_addr = 5'(a);
      #1 chk($sformatf("mid rdata r%0d", a), mfc0_rdata, 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset c%0d pc_redirect", c), {31'b0, pc_redirect}, 32'h0);
      chk($sformatf("post-reset c%0d flush", c), {31'b0, flush}, 32'h0);
    end

    // exception accepted on first edge after release
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    pendingexception = 1; exccode = 5'd1; exc_pc = 32'h80; mfc0_addr = 5'd14;
    @(posedge clk); #1;
    chk("first-edge flush", {31'b0, flush}, 32'h1);
    chk("first-edge epc", mfc0_rdata, 32'h80);
    @(negedge clk) pendingexception = 0;
    @(posedge clk); #1;
    chk("first-edge redirect", {31'b0, pc_redirect}, 32'h1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
